// File: rtl/mlp_mac_array.sv
// Multi-lane MAC engine: a broadcast activation times per-lane weights, with saturating
// accumulation and round/ReLU/saturate quantisation. Three-stage pipeline, full throughput.
module mlp_mac_array #(
  parameter int unsigned NUM_LANES  = 4,
  parameter int unsigned A_WIDTH    = 16,
  parameter int unsigned B_WIDTH    = 16,
  parameter int unsigned ACC_WIDTH  = 40,
  parameter int unsigned OUT_WIDTH  = 16,
  parameter int unsigned FRAC_SHIFT = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  input  logic                           in_first,
  input  logic                           in_last,
  input  logic                           relu_en,
  input  logic [A_WIDTH-1:0]             a,
  input  logic [NUM_LANES*B_WIDTH-1:0]   b,
  output logic                           out_valid,
  output logic [NUM_LANES*OUT_WIDTH-1:0] out_data,
  output logic [NUM_LANES-1:0]           sat_flag
);

  localparam int unsigned P_WIDTH = A_WIDTH + B_WIDTH;

  // Rounding addend 2^(FRAC_SHIFT-1), or zero when FRAC_SHIFT is 0.
  localparam logic signed [ACC_WIDTH:0] RND = ({{ACC_WIDTH{1'b0}}, 1'b1} << FRAC_SHIFT) >> 1;
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = ~ACC_MAX;
  localparam logic signed [ACC_WIDTH:0] OUT_MAX =
      {{(ACC_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] OUT_MIN = ~OUT_MAX;

  logic                         s1_valid_q, s1_first_q, s1_last_q, s1_relu_q;
  logic signed [P_WIDTH-1:0]    prod_d [NUM_LANES];
  logic signed [P_WIDTH-1:0]    prod_q [NUM_LANES];
  logic signed [ACC_WIDTH-1:0]  acc_d  [NUM_LANES];
  logic signed [ACC_WIDTH-1:0]  acc_q  [NUM_LANES];
  logic [NUM_LANES-1:0]         sticky_d, sticky_q;
  logic                         s2_last_q, s2_relu_q;
  logic                         out_valid_q;
  logic [NUM_LANES*OUT_WIDTH-1:0] out_data_d, out_data_q;
  logic [NUM_LANES-1:0]         sat_d, sat_q;

  // Stage 1: signed multiply.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      prod_d[i] = P_WIDTH'($signed(a)) * P_WIDTH'($signed(b[i*B_WIDTH +: B_WIDTH]));
    end
  end

  // Stage 2: load on first, otherwise saturating add.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      logic signed [ACC_WIDTH-1:0] prod_ext;
      logic signed [ACC_WIDTH:0]   sum;
      prod_ext    = ACC_WIDTH'(prod_q[i]);
      sum         = (ACC_WIDTH+1)'(acc_q[i]) + (ACC_WIDTH+1)'(prod_ext);
      acc_d[i]    = acc_q[i];
      sticky_d[i] = sticky_q[i];
      if (s1_valid_q) begin
        if (s1_first_q) begin
          acc_d[i]    = prod_ext;
          sticky_d[i] = 1'b0;
        end else if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
          acc_d[i]    = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
          sticky_d[i] = 1'b1;
        end else begin
          acc_d[i] = sum[ACC_WIDTH-1:0];
        end
      end
    end
  end

  // Stage 3: round half up, optional ReLU, saturate to the output width.
  always_comb begin
    out_data_d = '0;
    sat_d      = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      logic signed [ACC_WIDTH:0] rnd_sum;
      logic signed [ACC_WIDTH:0] r;
      logic                      osat;
      rnd_sum = (ACC_WIDTH+1)'(acc_q[i]) + RND;
      r       = rnd_sum >>> FRAC_SHIFT;
      osat    = 1'b0;
      if (s2_relu_q && r[ACC_WIDTH]) begin
        r = '0;
      end
      if (r > OUT_MAX) begin
        r    = OUT_MAX;
        osat = 1'b1;
      end else if (r < OUT_MIN) begin
        r    = OUT_MIN;
        osat = 1'b1;
      end
      out_data_d[i*OUT_WIDTH +: OUT_WIDTH] = r[OUT_WIDTH-1:0];
      sat_d[i] = sticky_q[i] | osat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_relu_q   <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_relu_q   <= 1'b0;
      sticky_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sat_q       <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        prod_q[i] <= '0;
        acc_q[i]  <= '0;
      end
    end else begin
      s1_valid_q <= in_valid;
      s1_first_q <= in_valid & in_first;
      s1_last_q  <= in_valid & in_last;
      s1_relu_q  <= in_valid & relu_en;
      if (in_valid) begin
        for (int i = 0; i < NUM_LANES; i++) prod_q[i] <= prod_d[i];
      end
      for (int i = 0; i < NUM_LANES; i++) acc_q[i] <= acc_d[i];
      sticky_q    <= sticky_d;
      s2_last_q   <= s1_valid_q & s1_last_q;
      s2_relu_q   <= s1_relu_q;
      out_valid_q <= s2_last_q;
      if (s2_last_q) begin
        out_data_q <= out_data_d;
        sat_q      <= sat_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sat_flag  = sat_q;

endmodule

// File: tb/tb_mlp_mac_array.sv
// Bench for mlp_mac_array: a default-sized instance and a 33-bit-accumulator instance share
// stimulus; expectations come from fixed vectors and an arithmetic reference model.
module tb_mlp_mac_array;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_first, in_last, relu_en;
  logic [15:0] a;
  logic [63:0] b;
  logic        ov0, ov1;
  logic [63:0] od0, od1;
  logic [3:0]  sf0, sf1;

  always #5 clk = ~clk;

  mlp_mac_array dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .relu_en(relu_en), .a(a), .b(b), .out_valid(ov0), .out_data(od0), .sat_flag(sf0)
  );

  mlp_mac_array #(.ACC_WIDTH(33)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .relu_en(relu_en), .a(a), .b(b), .out_valid(ov1), .out_data(od1), .sat_flag(sf1)
  );

  typedef struct {
    int          cyc;
    logic [63:0] data;
    logic [3:0]  sat;
  } exp_t;

  typedef struct {
    int       n;
    int       av[4];
    int       bv[4];
    bit       relu;
    int       ex[4];
    bit [3:0] es;
  } vec_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [63:0] last_d[2];
  logic [3:0]  last_s[2];
  longint      macc[2][4];
  bit          mstk[2][4];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the accumulate/quantise rules.
  function automatic void model(input int k, input int av, input int bv[4], input bit f,
                                input bit l, input bit rl, input bit use_tbl,
                                input int tex[4], input bit [3:0] tes);
    longint mx, mn, p, s, r;
    exp_t e;
    logic [15:0] t;
    mx = (longint'(1) <<< ((k == 0 ? 40 : 33) - 1)) - 1;
    mn = -mx - 1;
    e.cyc = cyc + 3;
    e.data = '0;
    e.sat = '0;
    for (int i = 0; i < 4; i++) begin
      p = longint'(av) * longint'(bv[i]);
      if (f) begin
        macc[k][i] = p;
        mstk[k][i] = 1'b0;
      end else begin
        s = macc[k][i] + p;
        if (s > mx) begin s = mx; mstk[k][i] = 1'b1; end
        else if (s < mn) begin s = mn; mstk[k][i] = 1'b1; end
        macc[k][i] = s;
      end
      if (l) begin
        r = (macc[k][i] + 128) >>> 8;
        if (rl && r < 0) r = 0;
        e.sat[i] = mstk[k][i];
        if (r > 32767) begin r = 32767; e.sat[i] = 1'b1; end
        else if (r < -32768) begin r = -32768; e.sat[i] = 1'b1; end
        t = r[15:0];
        if (use_tbl && k == 0) begin
          t = tex[i][15:0];
          e.sat[i] = tes[i];
        end
        e.data[i*16 +: 16] = t;
      end
    end
    if (l) begin
      if (k == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endfunction

  task automatic beat(input int av, input int bv[4], input bit f, input bit l, input bit rl,
                      input bit use_tbl, input int tex[4], input bit [3:0] tes);
    in_valid = 1'b1;
    in_first = f;
    in_last  = l;
    relu_en  = rl;
    a        = av[15:0];
    for (int i = 0; i < 4; i++) b[i*16 +: 16] = bv[i][15:0];
    model(0, av, bv, f, l, rl, use_tbl, tex, tes);
    model(1, av, bv, f, l, rl, use_tbl, tex, tes);
    @(posedge clk);
    #1;
  endtask

  // Idle cycle with junk on every qualifier that must be ignored.
  task automatic idle(input int n);
    for (int j = 0; j < n; j++) begin
      in_valid = 1'b0;
      in_first = 1'($urandom);
      in_last  = 1'($urandom);
      relu_en  = 1'($urandom);
      a        = 16'($urandom);
      b        = {$urandom, $urandom};
      @(posedge clk);
      #1;
    end
  endtask

  task automatic flush_model();
    q0.delete();
    q1.delete();
    for (int k = 0; k < 2; k++) begin
      last_d[k] = '0;
      last_s[k] = '0;
      for (int i = 0; i < 4; i++) begin
        macc[k][i] = 0;
        mstk[k][i] = 1'b0;
      end
    end
  endtask

  task automatic chk(input int k, input logic ov, input logic [63:0] od, input logic [3:0] sf);
    bit   has;
    bit   ev;
    exp_t e;
    has = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (has) e = (k == 0) ? q0[0] : q1[0];
    if (has && e.cyc < cyc) begin
      n_cmp++;
      n_fail++;
      $display("FAIL missed_result dut%0d: expected out_valid at cycle %0d, now %0d", k, e.cyc,
               cyc);
      if (k == 0) void'(q0.pop_front());
      else void'(q1.pop_front());
      has = 1'b0;
    end
    ev = has && (e.cyc == cyc);
    cmp($sformatf("out_valid dut%0d", k), {63'd0, ov}, {63'd0, ev});
    if (ev) begin
      last_d[k] = e.data;
      last_s[k] = e.sat;
      if (k == 0) void'(q0.pop_front());
      else void'(q1.pop_front());
    end
    cmp($sformatf("out_data dut%0d", k), od, last_d[k]);
    cmp($sformatf("sat_flag dut%0d", k), {60'd0, sf}, {60'd0, last_s[k]});
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk(0, ov0, od0, sf0);
      chk(1, ov1, od1, sf1);
    end
  end

  initial begin
    vec_t tbl[6];
    int   bb[4];
    int   z[4];
    int   n, av;
    bit   rl, nf;

    z = '{0, 0, 0, 0};
    tbl[0] = '{1, '{256, 0, 0, 0}, '{512, 0, 0, 0}, 1'b0, '{512, 0, 0, 0}, 4'b0000};
    tbl[1] = '{4, '{1, 2, 3, 4}, '{256, 512, 768, 1024}, 1'b0, '{10, 20, 30, 40}, 4'b0000};
    tbl[2] = '{1, '{100, 0, 0, 0}, '{256, 256, 256, 256}, 1'b0, '{100, 100, 100, 100},
               4'b0000};
    tbl[3] = '{1, '{1, 0, 0, 0}, '{384, -384, 127, 128}, 1'b0, '{2, -1, 0, 1}, 4'b0000};
    tbl[4] = '{1, '{1, 0, 0, 0}, '{384, -384, 127, 128}, 1'b1, '{2, 0, 0, 1}, 4'b0000};
    tbl[5] = '{1, '{32767, 0, 0, 0}, '{32767, -32768, 0, 256}, 1'b0, '{32767, -32768, 0, 32767},
               4'b0011};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    relu_en  = 1'b0;
    a        = '0;
    b        = '0;
    flush_model();
    #1;
    cmp("reset out_valid", {63'd0, ov0 | ov1}, 64'd0);
    cmp("reset out_data dut0", od0, 64'd0);
    cmp("reset out_data dut1", od1, 64'd0);
    cmp("reset sat_flag", {56'd0, sf0, sf1}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Fixed vectors, issued back to back.
    for (int t = 0; t < 6; t++) begin
      for (int j = 0; j < tbl[t].n; j++) begin
        beat(tbl[t].av[j], tbl[t].bv, j == 0, j == tbl[t].n - 1, tbl[t].relu, 1'b1, tbl[t].ex,
             tbl[t].es);
      end
    end
    idle(4);

    // Accumulator saturation on the 33-bit instance, then recovery on the next first beat.
    bb = '{32767, 32767, 32767, 32767};
    for (int j = 0; j < 6; j++) beat(32767, bb, j == 0, j == 5, 1'b0, 1'b0, z, 4'b0);
    idle(4);
    cmp("acc_sat data dut1", {48'd0, od1[15:0]}, 64'd32767);
    cmp("acc_sat flag dut1", {60'd0, sf1}, 64'hf);
    bb = '{256, 256, 256, 256};
    beat(256, bb, 1'b1, 1'b1, 1'b0, 1'b0, z, 4'b0);
    idle(4);
    cmp("acc_sat clear data dut1", {48'd0, od1[15:0]}, 64'd256);
    cmp("acc_sat clear flag dut1", {60'd0, sf1}, 64'h0);

    // Reset in the middle of a vector.
    beat(tbl[1].av[0], tbl[1].bv, 1'b1, 1'b0, 1'b0, 1'b0, z, 4'b0);
    beat(tbl[1].av[1], tbl[1].bv, 1'b0, 1'b0, 1'b0, 1'b0, z, 4'b0);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    flush_model();
    cmp("midreset out_valid", {63'd0, ov0 | ov1}, 64'd0);
    cmp("midreset out_data", od0 | od1, 64'd0);
    cmp("midreset sat_flag", {60'd0, sf0 | sf1}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      beat(tbl[1].av[j], tbl[1].bv, j == 0, j == 3, 1'b0, 1'b1, tbl[1].ex, tbl[1].es);
    end
    idle(4);

    // Random vectors with bubbles, mixed magnitudes and occasional missing first.
    for (int v = 0; v < 300; v++) begin
      n  = int'($urandom_range(1, 5));
      rl = 1'($urandom);
      nf = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < 4; i++) begin
        bb[i] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 65535)) - 32768
                                             : int'($urandom_range(0, 4000)) - 2000;
      end
      for (int j = 0; j < n; j++) begin
        av = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 65535)) - 32768
                                          : int'($urandom_range(0, 4000)) - 2000;
        beat(av, bb, (j == 0) && !nf, j == n - 1, rl, 1'b0, z, 4'b0);
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
      end
    end
    idle(6);
    cmp("drain dut0", 64'(q0.size()), 64'd0);
    cmp("drain dut1", 64'(q1.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mlp_mac_array.md
# mlp_mac_array

Parametrised multi-lane multiply-accumulate engine for the MLP datapath. It computes NUM_LANES dot products in parallel: one activation per beat is broadcast to every lane, and each lane receives its own weight. Each lane has a pipelined signed multiplier, a saturating accumulator, and an output quantiser (round, optional ReLU, saturate). It sits between the weight/activation fetch logic and the layer output buffer, and processes one neuron group per vector.

## Interface
Parameters:
- NUM_LANES, 4, number of parallel MAC lanes (≥1)
- A_WIDTH, 16, signed activation width
- B_WIDTH, 16, signed weight width per lane
- ACC_WIDTH, 40, signed accumulator width (must be ≥ A_WIDTH+B_WIDTH)
- OUT_WIDTH, 16, signed quantised output width per lane (must be ≤ ACC_WIDTH)
- FRAC_SHIFT, 8, arithmetic right shift applied at quantisation (0 ≤ FRAC_SHIFT < ACC_WIDTH)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  beat valid; a and b are sampled on the clk edge where this is high
- in_first  in  1  qualifies a beat as the first term of a vector; the accumulator loads instead of adding
- in_last  in  1  qualifies a beat as the last term of a vector; triggers quantisation and output
- relu_en  in  1  sampled with the in_last beat; clamps negative results to 0
- a  in  A_WIDTH  signed activation, broadcast to all lanes
- b  in  NUM_LANES*B_WIDTH  signed weights; lane i uses b[i*B_WIDTH +: B_WIDTH]
- out_valid  out  1  one-cycle pulse when out_data holds a new result
- out_data  out  NUM_LANES*OUT_WIDTH  quantised results; lane i at [i*OUT_WIDTH +: OUT_WIDTH]
- sat_flag  out  NUM_LANES  per lane: the accumulator or output saturated during this vector

## Operation
- Stage 1 (multiply): on each in_valid beat, register prod_i = a*b_i (A_WIDTH+B_WIDTH signed) together with the tags first/last/relu. A beat with in_valid=0 propagates a bubble; in_first, in_last and relu_en are ignored when in_valid=0.
- Stage 2 (accumulate), on a valid stage-1 entry:
  - Sign-extend the product to ACC_WIDTH.
  - If the tag is first: acc_i ← prod_ext and the sticky sat bit ← 0.
  - Otherwise: compute acc_i + prod_ext in ACC_WIDTH+1 bits and clamp to [−2^(ACC_WIDTH−1), 2^(ACC_WIDTH−1)−1]. If clamping occurs, set the sticky sat bit.
  - Bubbles leave acc_i unchanged.
- Stage 3 (quantise), taken when the stage-2 entry has the last tag. It uses the acc value already including the last term.
  - Round half up: r = (acc + 2^(FRAC_SHIFT−1)) >>> FRAC_SHIFT, computed in ACC_WIDTH+1 bits. When FRAC_SHIFT=0 there is no addend.
  - If relu: r < 0 → 0.
  - Saturate r to the signed OUT_WIDTH range.
  - sat_flag_i = sticky accumulator bit OR output clamp. This includes any accumulator clamp on the last beat itself.
- Both first and last on one beat: a single-term vector, handled correctly.
- A beat without first and with no prior first accumulates onto the current acc (0 after reset).
- Back-to-back vectors: a first beat may directly follow a last beat with no gap. Every last beat produces exactly one out_valid.
- out_data and sat_flag hold their value until the next out_valid.

## Timing
- Reset (async assert, sync deassert handled upstream): out_valid=0, out_data=0, sat_flag=0, all acc=0, all pipeline valid bits and tags=0.
- Full throughput: one beat per cycle, no stall or backpressure. The consumer must accept every out_valid pulse.
- Latency: last beat sampled at edge E0 → product registered at E0 → acc updated at E1 → out_data/out_valid registered at E2. out_valid is high for exactly the cycle between E2 and E3.
- Bubbles between beats of a vector add latency only; the result is identical.
- Reset mid-vector: all in-flight beats are discarded and no out_valid is produced for that vector. The first beat after reset must carry in_first.

## Test plan
- Basic lane: a=256 (in_first & in_last), b_0=512, FRAC_SHIFT=8 → out_data lane0=512, other lanes 0 (b=0), sat_flag=0, out_valid exactly 3 edges after the beat.
- 4-term vector with back-to-back second vector: vector 1 a={1,2,3,4}, b_i=256*(i+1) → lane i = 10*(i+1). Vector 2 starts the next cycle with a=100, b=256 (first & last) → 100 in all lanes. Check two single-cycle out_valid pulses.
- Rounding and ReLU: acc=384 → 2; acc=−384 → −1 with relu_en=0, 0 with relu_en=1; acc=127 → 0; acc=128 → 1.
- Output saturation: a=32767, b=32767 single term → product 1073676289, >>8 exceeds the range → 32767 and sat_flag=1. Same with b=−32768 → −32768 and sat_flag=1.
- Accumulator saturation with ACC_WIDTH=33: five beats of a=b=32767 → acc clamps at 4294967295 and stays there, sat_flag=1. The next vector with first has sat_flag=0.
- Reset mid-vector: assert rst_n=0 after 2 of 4 beats → outputs 0 immediately and no out_valid. A new vector afterwards gives the correct result.
